bilinear_coord_gen: RTL and testbench
=====================================

# bilinear_coord_gen

Upstream companion of the bilinear interpolation stage in the scale-down path. For every destination pixel it computes the Q12.16 source coordinate and issues read addresses for the two source columns to the two-row line buffer. It emits the four 17-bit bilinear weights, delayed to line up with the line-buffer read data, so the interpolator receives weights and the four neighbour pixels on the same cycle. It also tells the line-buffer writer which source row pair it needs, and stalls between rows until that pair is present.

## Interface
- SRC_W, 640, source width in pixels
- SRC_H, 480, source height in lines
- DST_W, 320, destination width
- DST_H, 240, destination height
- RD_LAT, 2, line-buffer read latency in cycles (≥1)
- vin_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_sync_n  in  1  active-low synchronous frame abort; same effect as rst
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE
- x_step  in  28  horizontal step, Q12.16 (SRC_W/DST_W); sampled at frame_start
- y_step  in  28  vertical step, Q12.16; sampled at frame_start
- line_ready  in  1  line buffer holds rows req_row and min(req_row+1, SRC_H-1)
- req_row  out  12  integer source row y0 currently required
- rd_en  out  1  line-buffer read strobe
- rd_addr_x0  out  12  source column x0
- rd_addr_x1  out  12  source column x1 = min(x0+1, SRC_W-1)
- coo_valid  out  1  weights valid, aligned with the line-buffer data
- coefficient1..coefficient4  out  17 each  weights of x0, x1, y0, y1 (Q1.16)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on the cycle of the last coo_valid

## Operation
- FSM states: IDLE, WAIT_LINE, RUN, ROW_END.
- IDLE + frame_start: latch x_step and y_step; clear x_acc, y_acc, ox and oy; go to WAIT_LINE.
- WAIT_LINE: req_row = min(y_acc[27:16], SRC_H-1). If line_ready is high, go to RUN; otherwise hold with rd_en=0.
- RUN: each cycle do all of the following, then after the cycle with ox==DST_W-1 go to ROW_END.
  - Assert rd_en.
  - x0 = min(x_acc[27:16], SRC_W-1) and x1 = min(x0+1, SRC_W-1).
  - x_acc += x_step and ox++.
- line_ready is ignored during RUN; a row always issues without gaps.
- ROW_END: y_acc += y_step, oy++ and x_acc = 0.
  - If oy was DST_H-1, go to IDLE.
  - Otherwise go to WAIT_LINE.
- Weights:
  - fx = x_acc[15:0] and fy = y_acc[15:0], sampled with the same issue.
  - coefficient1 = 17'h10000 − fx and coefficient2 = fx.
  - coefficient3 = 17'h10000 − fy and coefficient4 = fy.
  - When x0 or y0 is clamped, the fraction is forced to 0: coefficient1 or coefficient3 = 65536, coefficient2 or coefficient4 = 0.
- Weight arithmetic is unsigned with no overflow. The pairs always satisfy coefficient1+coefficient2 = coefficient3+coefficient4 = 65536.
- Delay line: {valid, coefficient1..4, last flag} is delayed by RD_LAT registers, giving coo_valid and the coefficient outputs. frame_done is the delayed last flag, i.e. the final pixel of row DST_H-1.
- Accumulators are 28 bits wide. Integer overflow past 4095 is not possible for legal steps; the clamps cover overshoot.
- rst or a low frame_sync_n, on any cycle:
  - The FSM goes to IDLE and the whole delay line is cleared.
  - All outputs take their reset values on the next edge.
  - In-flight coo_valid pulses are lost.
- frame_start outside IDLE is ignored.

## Timing
- Reset values:
  - rd_en, coo_valid, busy and frame_done are 0.
  - req_row, rd_addr_x0 and rd_addr_x1 are 0.
  - coefficient1..4 are 0.
- frame_start at edge T moves the FSM to WAIT_LINE at T+1.
- With line_ready already high, the first rd_en is at T+2 and the first coo_valid at T+2+RD_LAT.
- Latency from rd_en to coo_valid is exactly RD_LAT cycles. Address and weights belong to the same issue cycle.
- Minimum row period is DST_W+2 cycles: DST_W RUN cycles, 1 ROW_END cycle and ≥1 WAIT_LINE cycle.
- req_row changes only on the ROW_END→WAIT_LINE transition and stays stable through WAIT_LINE and RUN.
- coo_valid is high for DST_W consecutive cycles per row, and DST_W·DST_H times per frame.

## Test plan
- 640×480→320×240, x_step=y_step=0x20000, line_ready tied 1 -> rd_addr_x0 = 0,2,4…638 each row; coefficient1=65536, coefficient2=0; 320 coo_valid per row; 240 rows; one frame_done on the final coo_valid.
- x_step=0x18000 -> second issue of a row has x0=1, x1=2, coefficient1=coefficient2=32768; third issue has x0=3, fx=0.
- SRC_W=8, DST_W=4, x_step=0x24000 -> the fourth issue computes x=6.75, so x0=6, x1=7 with no clamp. Then force x_step=0x30000 -> x0 clamps to 7, x1=7, coefficient1=65536.
- line_ready low for 100 cycles after row 5 -> rd_en stays 0; req_row holds y0 of row 6; issue resumes 1 cycle after line_ready rises.
- frame_sync_n low for 1 cycle mid-row -> next edge gives rd_en=0, coo_valid=0, busy=0 and no frame_done; a new frame_start restarts at ox=oy=0.
- frame_start pulsed during RUN -> ignored: count and steps unchanged. rst asserted mid-frame -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/bilinear_coord_gen.sv
// bilinear_coord_gen: walks the destination raster in Q12.16 source space.
// For each destination pixel it issues the two source column addresses to
// the line buffer and delays the bilinear weights by the line-buffer read
// latency, so the interpolator sees weights and pixels on the same cycle.
module bilinear_coord_gen #(
    parameter int SRC_W  = 640,
    parameter int SRC_H  = 480,
    parameter int DST_W  = 320,
    parameter int DST_H  = 240,
    parameter int RD_LAT = 2
) (
    input  logic        vin_clk,
    input  logic        rst,
    input  logic        frame_sync_n,
    input  logic        frame_start,
    input  logic [27:0] x_step,
    input  logic [27:0] y_step,
    input  logic        line_ready,
    output logic [11:0] req_row,
    output logic        rd_en,
    output logic [11:0] rd_addr_x0,
    output logic [11:0] rd_addr_x1,
    output logic        coo_valid,
    output logic [16:0] coefficient1,
    output logic [16:0] coefficient2,
    output logic [16:0] coefficient3,
    output logic [16:0] coefficient4,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [11:0] SRC_W_M1 = 12'(SRC_W - 1);
    localparam logic [11:0] SRC_H_M1 = 12'(SRC_H - 1);
    localparam logic [11:0] DST_W_C  = 12'(DST_W);
    localparam logic [11:0] DST_W_M1 = 12'(DST_W - 1);
    localparam logic [11:0] DST_H_M1 = 12'(DST_H - 1);
    localparam logic [16:0] ONE      = 17'h10000;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, RUN, ROW_END} state_t;

    // One entry of the weight delay line.
    typedef struct packed {
        logic        vld;
        logic [16:0] c1;
        logic [16:0] c2;
        logic [16:0] c3;
        logic [16:0] c4;
        logic        last;
    } wt_t;

    state_t      state;
    logic [27:0] xs, ys, x_acc, y_acc;
    logic [11:0] ox, oy;
    logic        kill, issue, x_clamp, y_clamp;
    logic [11:0] x_int, x0, x1;
    logic [15:0] fx, fy;
    wt_t         iss_wt;
    wt_t         wt_pipe [RD_LAT:0];

    // Integer row clamped into the source image.
    function automatic logic [11:0] clamp_row(input logic [27:0] acc);
        return (acc[27:16] > SRC_H_M1) ? SRC_H_M1 : acc[27:16];
    endfunction

    assign kill = rst || !frame_sync_n;
    assign busy = (state != IDLE);

    // Issue-cycle address and weight math; the first pixel of a row is
    // issued on the same edge that leaves WAIT_LINE so rd_en stays registered.
    always_comb begin
        issue   = ((state == WAIT_LINE) && line_ready) ||
                  ((state == RUN) && (ox != DST_W_C));
        x_int   = x_acc[27:16];
        x_clamp = (x_int > SRC_W_M1);
        x0      = x_clamp ? SRC_W_M1 : x_int;
        x1      = (x0 == SRC_W_M1) ? SRC_W_M1 : x0 + 12'd1;
        fx      = x_clamp ? 16'd0 : x_acc[15:0];
        y_clamp = (y_acc[27:16] > SRC_H_M1);
        fy      = y_clamp ? 16'd0 : y_acc[15:0];
        iss_wt.vld  = issue;
        iss_wt.c1   = ONE - {1'b0, fx};
        iss_wt.c2   = {1'b0, fx};
        iss_wt.c3   = ONE - {1'b0, fy};
        iss_wt.c4   = {1'b0, fy};
        iss_wt.last = issue && (ox == DST_W_M1) && (oy == DST_H_M1);
    end

    // Frame FSM, accumulators and registered read-address outputs.
    always_ff @(posedge vin_clk) begin
        if (kill) begin
            state      <= IDLE;
            xs         <= '0;
            ys         <= '0;
            x_acc      <= '0;
            y_acc      <= '0;
            ox         <= '0;
            oy         <= '0;
            req_row    <= '0;
            rd_en      <= 1'b0;
            rd_addr_x0 <= '0;
            rd_addr_x1 <= '0;
        end else begin
            case (state)
                IDLE: if (frame_start) begin
                    xs      <= x_step;
                    ys      <= y_step;
                    x_acc   <= '0;
                    y_acc   <= '0;
                    ox      <= '0;
                    oy      <= '0;
                    req_row <= '0;
                    state   <= WAIT_LINE;
                end
                WAIT_LINE: if (line_ready) state <= RUN;
                RUN: if (ox == DST_W_C) state <= ROW_END;
                ROW_END: begin
                    y_acc <= y_acc + ys;
                    oy    <= oy + 12'd1;
                    x_acc <= '0;
                    ox    <= '0;
                    if (oy == DST_H_M1) begin
                        state <= IDLE;
                    end else begin
                        state   <= WAIT_LINE;
                        req_row <= clamp_row(y_acc + ys);
                    end
                end
                default: state <= IDLE;
            endcase
            rd_en <= issue;
            if (issue) begin
                x_acc      <= x_acc + xs;
                ox         <= ox + 12'd1;
                rd_addr_x0 <= x0;
                rd_addr_x1 <= x1;
            end
        end
    end

    // Weight delay line: stage 0 lines up with rd_en, stage RD_LAT with the data.
    always_ff @(posedge vin_clk) begin
        if (kill) begin
            for (int i = 0; i <= RD_LAT; i++) wt_pipe[i] <= '0;
        end else begin
            wt_pipe[0] <= issue ? iss_wt : '0;
            for (int i = 1; i <= RD_LAT; i++) wt_pipe[i] <= wt_pipe[i-1];
        end
    end

    assign coo_valid    = wt_pipe[RD_LAT].vld;
    assign coefficient1 = wt_pipe[RD_LAT].c1;
    assign coefficient2 = wt_pipe[RD_LAT].c2;
    assign coefficient3 = wt_pipe[RD_LAT].c3;
    assign coefficient4 = wt_pipe[RD_LAT].c4;
    assign frame_done   = wt_pipe[RD_LAT].last;

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Scoreboard bench for bilinear_coord_gen on a small 8x6 -> 4x3 raster.
module tb_bilinear_coord_gen;

    localparam int SRC_W = 8, SRC_H = 6, DST_W = 4, DST_H = 3, RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, frame_sync_n, frame_start, line_ready;
    logic [27:0] x_step, y_step;
    logic [11:0] req_row, rd_addr_x0, rd_addr_x1;
    logic        rd_en, coo_valid, busy, frame_done;
    logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;

    bilinear_coord_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W),
                         .DST_H(DST_H), .RD_LAT(RD_LAT)) dut (
        .vin_clk(clk), .rst(rst), .frame_sync_n(frame_sync_n),
        .frame_start(frame_start), .x_step(x_step), .y_step(y_step),
        .line_ready(line_ready), .req_row(req_row), .rd_en(rd_en),
        .rd_addr_x0(rd_addr_x0), .rd_addr_x1(rd_addr_x1),
        .coo_valid(coo_valid), .coefficient1(coefficient1),
        .coefficient2(coefficient2), .coefficient3(coefficient3),
        .coefficient4(coefficient4), .busy(busy), .frame_done(frame_done));

    always #5 clk = ~clk;

    typedef struct packed {logic [11:0] x0, x1; logic [16:0] c1, c2;} xent_t;
    typedef struct packed {logic [11:0] y0; logic [16:0] c3, c4;} yent_t;
    typedef struct packed {
        logic [11:0] x0, x1, row;
        logic [16:0] c1, c2, c3, c4;
        logic        last;
    } sb_t;

    sb_t iss_q[$];
    sb_t coo_q[$];
    int  lat_q[$];
    int  n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic xent_t xe(input int a, input int b, input int c, input int d);
        xent_t e;
        e.x0 = 12'(a); e.x1 = 12'(b); e.c1 = 17'(c); e.c2 = 17'(d);
        return e;
    endfunction

    function automatic yent_t ye(input int a, input int c, input int d);
        yent_t e;
        e.y0 = 12'(a); e.c3 = 17'(c); e.c4 = 17'(d);
        return e;
    endfunction

    // Expected frame = cartesian product of the hand-computed column and row tables.
    task automatic push_frame(input xent_t a0, a1, a2, a3, input yent_t b0, b1, b2);
        xent_t xa [4];
        yent_t ya [3];
        sb_t   e;
        xa[0] = a0; xa[1] = a1; xa[2] = a2; xa[3] = a3;
        ya[0] = b0; ya[1] = b1; ya[2] = b2;
        for (int r = 0; r < DST_H; r++)
            for (int i = 0; i < DST_W; i++) begin
                e.x0 = xa[i].x0; e.x1 = xa[i].x1; e.c1 = xa[i].c1; e.c2 = xa[i].c2;
                e.row = ya[r].y0; e.c3 = ya[r].c3; e.c4 = ya[r].c4;
                e.last = (r == DST_H-1) && (i == DST_W-1);
                iss_q.push_back(e);
                coo_q.push_back(e);
            end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic flush();
        iss_q.delete(); coo_q.delete(); lat_q.delete();
    endtask

    task automatic start_frame(input logic [27:0] xs, input logic [27:0] ys);
        x_step = xs; y_step = ys; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        x_step = 28'hFFFFFFF; y_step = 28'hFFFFFFF;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);       chk({tag, "_coo_valid"}, coo_valid, 0);
        chk({tag, "_busy"}, busy, 0);         chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_req_row"}, req_row, 0);   chk({tag, "_x0"}, rd_addr_x0, 0);
        chk({tag, "_x1"}, rd_addr_x1, 0);     chk({tag, "_c1"}, coefficient1, 0);
        chk({tag, "_c2"}, coefficient2, 0);   chk({tag, "_c3"}, coefficient3, 0);
        chk({tag, "_c4"}, coefficient4, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 500) begin tick(); n++; end
        chk({tag, "_frame_done_seen"}, frame_done, 1);
        repeat (3) tick();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_iss_q_empty"}, iss_q.size(), 0);
        chk({tag, "_coo_q_empty"}, coo_q.size(), 0);
    endtask

    // Monitor: pops an expectation for every rd_en and every coo_valid.
    initial forever begin
        sb_t e;
        @(negedge clk);
        cyc++;
        if (rd_en) begin
            chk("iss_q_nonempty", iss_q.size() != 0, 1);
            if (iss_q.size() != 0) begin
                e = iss_q.pop_front();
                chk("rd_addr_x0", rd_addr_x0, e.x0);
                chk("rd_addr_x1", rd_addr_x1, e.x1);
                chk("req_row", req_row, e.row);
            end
            lat_q.push_back(cyc);
        end
        if (coo_valid) begin
            chk("coo_q_nonempty", coo_q.size() != 0, 1);
            if (coo_q.size() != 0) begin
                e = coo_q.pop_front();
                chk("coefficient1", coefficient1, e.c1);
                chk("coefficient2", coefficient2, e.c2);
                chk("coefficient3", coefficient3, e.c3);
                chk("coefficient4", coefficient4, e.c4);
                chk("frame_done", frame_done, e.last);
            end
            if (lat_q.size() != 0) chk("rd_to_coo_latency", cyc - lat_q.pop_front(), RD_LAT);
            else chk("lat_q_nonempty", lat_q.size(), 1);
        end else if (frame_done) begin
            chk("frame_done_without_coo", coo_valid, 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; frame_sync_n = 1'b1; frame_start = 1'b0; line_ready = 1'b0;
        x_step = '0; y_step = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Frame A: 2:1 both ways, timing from frame_start to frame_done.
        line_ready = 1'b1;
        push_frame(xe(0,1,65536,0), xe(2,3,65536,0), xe(4,5,65536,0), xe(6,7,65536,0),
                   ye(0,65536,0), ye(2,65536,0), ye(4,65536,0));
        start_frame(28'h20000, 28'h20000);
        chk("A_busy_wait_line", busy, 1);
        chk("A_rd_en_wait_line", rd_en, 0);
        tick();
        chk("A_first_rd_en", rd_en, 1);
        n = 0;
        while (!frame_done && n < 200) begin tick(); n++; end
        chk("A_cycles_to_frame_done", n, 17);
        chk("A_busy_at_done", busy, 0);
        wait_done("A");

        // Frame B: fractional steps; a frame_start mid-row must be ignored.
        push_frame(xe(0,1,65536,0), xe(1,2,32768,32768), xe(3,4,65536,0), xe(4,5,32768,32768),
                   ye(0,65536,0), ye(2,32768,32768), ye(5,65536,0));
        start_frame(28'h18000, 28'h28000);
        repeat (3) tick();
        x_step = 28'h10000; y_step = 28'h10000; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("B_busy_after_ignored_start", busy, 1);
        wait_done("B");

        // Frame C: no clamp at x=6.75, y clamps at row 2; line_ready stalls.
        line_ready = 1'b0;
        push_frame(xe(0,1,65536,0), xe(2,3,49152,16384), xe(4,5,32768,32768), xe(6,7,16384,49152),
                   ye(0,65536,0), ye(3,65536,0), ye(5,65536,0));
        start_frame(28'h24000, 28'h30000);
        repeat (100) begin tick(); chk("C_stall0_rd_en", rd_en, 0); end
        chk("C_stall0_req_row", req_row, 0);
        line_ready = 1'b1;
        tick();
        chk("C_resume0_rd_en", rd_en, 1);
        line_ready = 1'b0;
        n = 0;
        while (rd_en && n < 20) begin tick(); n++; end
        chk("C_row0_ended", rd_en, 0);
        repeat (100) begin tick(); chk("C_stall1_rd_en", rd_en, 0); end
        chk("C_stall1_req_row", req_row, 3);
        chk("C_stall1_busy", busy, 1);
        line_ready = 1'b1;
        tick();
        chk("C_resume1_rd_en", rd_en, 1);
        wait_done("C");

        // Frame D: x clamps at 9 -> 7; abort mid-row then restart from scratch.
        push_frame(xe(0,1,65536,0), xe(3,4,65536,0), xe(6,7,65536,0), xe(7,7,65536,0),
                   ye(0,65536,0), ye(1,32768,32768), ye(3,65536,0));
        start_frame(28'h30000, 28'h18000);
        n = 0;
        for (int k = 0; k < 100 && n < 6; k++) begin tick(); if (rd_en) n++; end
        chk("D_reached_row1", n, 6);
        frame_sync_n = 1'b0;
        tick();
        chk_zero("abort");
        flush();
        frame_sync_n = 1'b1;
        repeat (10) tick();
        chk("D_idle_after_abort", busy, 0);
        push_frame(xe(0,1,65536,0), xe(3,4,65536,0), xe(6,7,65536,0), xe(7,7,65536,0),
                   ye(0,65536,0), ye(1,32768,32768), ye(3,65536,0));
        start_frame(28'h30000, 28'h18000);
        wait_done("D");

        // rst mid-frame, then a clean frame B.
        push_frame(xe(0,1,65536,0), xe(2,3,49152,16384), xe(4,5,32768,32768), xe(6,7,16384,49152),
                   ye(0,65536,0), ye(3,65536,0), ye(5,65536,0));
        start_frame(28'h24000, 28'h30000);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk_zero("rst_mid");
        flush();
        rst = 1'b0;
        tick();
        push_frame(xe(0,1,65536,0), xe(1,2,32768,32768), xe(3,4,65536,0), xe(4,5,32768,32768),
                   ye(0,65536,0), ye(2,32768,32768), ye(5,65536,0));
        start_frame(28'h18000, 28'h28000);
        wait_done("B2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
